// File: rtl/dmem_pkg.sv
// dmem_pkg: shared data-memory widths and arbiter state encoding
package dmem_pkg;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} arb_state_t;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares dmem between the core (zero-latency owner) and a debug req/ack port
module dmem_arbiter #(
  parameter int ADDR_W = dmem_pkg::ADDR_W,
  parameter int DATA_W = dmem_pkg::DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic [DATA_W-1:0] cpu_rd,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_adr,
  input  logic [DATA_W-1:0] dbg_wd,
  output logic [DATA_W-1:0] dbg_rd,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);
  import dmem_pkg::*;
  arb_state_t state;
  logic [2:0] wait_cnt;
  logic dbg_grant, starved;
  assign starved = wait_cnt == 3'(MAX_WAIT);
  assign dbg_grant = state == IDLE && dbg_req && (!cpu_req || starved);
  assign mem_adr = dbg_grant ? dbg_adr : cpu_adr;
  assign mem_wd = dbg_grant ? dbg_wd : cpu_wd;
  assign mem_we = dbg_grant ? dbg_we : cpu_we & cpu_req;
  assign cpu_rd = mem_rd;
  assign cpu_stall = dbg_grant & cpu_req;
  // In IDLE without a grant and with dbg_req high, cpu_req must be high: that is a denied cycle.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      dbg_ack <= 1'b0;
      dbg_rd <= '0;
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      if (dbg_grant) begin
        dbg_rd <= mem_rd;
        dbg_ack <= 1'b1;
        state <= ACK;
        wait_cnt <= '0;
      end else if (!dbg_req) wait_cnt <= '0;
      else if (!starved) wait_cnt <= wait_cnt + 3'd1;
    end else if (!dbg_req) begin
      dbg_ack <= 1'b0;
      state <= IDLE;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenario tasks against a behavioural 8x8 dmem
module tb_dmem_arbiter;
  logic clk = 0, reset = 0;
  logic cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [2:0] cpu_adr = 0, dbg_adr = 0, mem_adr;
  logic [7:0] cpu_wd = 0, dbg_wd = 0, cpu_rd, dbg_rd, mem_wd, mem_rd;
  logic cpu_stall, dbg_ack, mem_we;
  logic [7:0] mem [8];
  int checks = 0, failures = 0;

  dmem_arbiter #(.ADDR_W(3), .DATA_W(8), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wd(dbg_wd),
    .dbg_rd(dbg_rd), .dbg_ack(dbg_ack),
    .mem_adr(mem_adr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) mem[mem_adr] <= mem_wd;
  assign mem_rd = mem[mem_adr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 0; dbg_req = 1; dbg_adr = 3; cpu_req = 1;
    step(); step(); #2;
    checks++; if (dbg_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0h exp=0", dbg_ack); end
    checks++; if (dbg_rd !== 8'h00) begin failures++; $display("FAIL reset_rd got=%0h exp=0", dbg_rd); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", cpu_stall); end
    reset = 1; step();
    checks++; if (dbg_ack !== 1'b0) begin failures++; $display("FAIL reset_nogrant_busy got=%0h exp=0", dbg_ack); end
    cpu_req = 0; #2;
    checks++; if (mem_adr !== 3'd3) begin failures++; $display("FAIL reset_first_grant_adr got=%0h exp=3", mem_adr); end
    step();
    checks++; if (dbg_ack !== 1'b1) begin failures++; $display("FAIL reset_first_grant_ack got=%0h exp=1", dbg_ack); end
    dbg_req = 0; step();
    checks++; if (dbg_ack !== 1'b0) begin failures++; $display("FAIL reset_ack_drop got=%0h exp=0", dbg_ack); end
  endtask

  task automatic test_core_only();
    cpu_req = 1; cpu_we = 1; cpu_adr = 4; cpu_wd = 8'd28; #2;
    checks++; if (mem_adr !== 3'd4) begin failures++; $display("FAIL core_adr got=%0h exp=4", mem_adr); end
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL core_we got=%0h exp=1", mem_we); end
    checks++; if (mem_wd !== 8'd28) begin failures++; $display("FAIL core_wd got=%0h exp=1c", mem_wd); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL core_stall got=%0h exp=0", cpu_stall); end
    step();
    cpu_we = 0; #2;
    checks++; if (cpu_rd !== 8'd28) begin failures++; $display("FAIL core_read got=%0h exp=1c", cpu_rd); end
    cpu_req = 0; cpu_we = 1; #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL core_we_gated got=%0h exp=0", mem_we); end
    cpu_we = 0; step();
  endtask

  task automatic test_debug_read();
    cpu_req = 0; cpu_adr = 1; dbg_req = 1; dbg_we = 0; dbg_adr = 4; #2;
    checks++; if (mem_adr !== 3'd4) begin failures++; $display("FAIL dbgrd_adr got=%0h exp=4", mem_adr); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL dbgrd_we got=%0h exp=0", mem_we); end
    step();
    checks++; if (dbg_ack !== 1'b1) begin failures++; $display("FAIL dbgrd_ack got=%0h exp=1", dbg_ack); end
    checks++; if (dbg_rd !== 8'd28) begin failures++; $display("FAIL dbgrd_data got=%0h exp=1c", dbg_rd); end
    checks++; if (mem_adr !== 3'd1) begin failures++; $display("FAIL dbgrd_ack_nogrant got=%0h exp=1", mem_adr); end
    dbg_req = 0; #2;
    checks++; if (dbg_ack !== 1'b1) begin failures++; $display("FAIL dbgrd_ack_hold got=%0h exp=1", dbg_ack); end
    step();
    checks++; if (dbg_ack !== 1'b0) begin failures++; $display("FAIL dbgrd_ack_fall got=%0h exp=0", dbg_ack); end
  endtask

  task automatic test_starvation();
    cpu_req = 1; cpu_we = 0; cpu_adr = 1; dbg_req = 1; dbg_we = 1; dbg_adr = 7; dbg_wd = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL starve_stall_%0d got=%0h exp=0", i, cpu_stall); end
      checks++; if (mem_adr !== 3'd1) begin failures++; $display("FAIL starve_adr_%0d got=%0h exp=1", i, mem_adr); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL starve_we_%0d got=%0h exp=0", i, mem_we); end
      step();
    end
    #2;
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL starve_forced_stall got=%0h exp=1", cpu_stall); end
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL starve_forced_we got=%0h exp=1", mem_we); end
    checks++; if (mem_adr !== 3'd7) begin failures++; $display("FAIL starve_forced_adr got=%0h exp=7", mem_adr); end
    checks++; if (mem_wd !== 8'hA5) begin failures++; $display("FAIL starve_forced_wd got=%0h exp=a5", mem_wd); end
    step();
    checks++; if (dbg_ack !== 1'b1) begin failures++; $display("FAIL starve_ack got=%0h exp=1", dbg_ack); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL starve_stall_clear got=%0h exp=0", cpu_stall); end
    checks++; if (mem[7] !== 8'hA5) begin failures++; $display("FAIL starve_mem7 got=%0h exp=a5", mem[7]); end
    checks++; if (mem[1] === 8'hA5) begin failures++; $display("FAIL starve_mem1_clobber got=%0h exp=not a5", mem[1]); end
  endtask

  task automatic test_held_request();
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL held_we_%0d got=%0h exp=0", i, mem_we); end
      checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL held_stall_%0d got=%0h exp=0", i, cpu_stall); end
      checks++; if (dut.wait_cnt !== 3'd0) begin failures++; $display("FAIL held_wait_%0d got=%0h exp=0", i, dut.wait_cnt); end
      checks++; if (dbg_ack !== 1'b1) begin failures++; $display("FAIL held_ack_%0d got=%0h exp=1", i, dbg_ack); end
      step();
    end
    dbg_req = 0; dbg_we = 0; cpu_req = 0; step();
    checks++; if (dbg_ack !== 1'b0) begin failures++; $display("FAIL held_ack_fall got=%0h exp=0", dbg_ack); end
  endtask

  task automatic test_reset_mid_handshake();
    dbg_req = 1; dbg_we = 0; dbg_adr = 4; step();
    checks++; if (dbg_ack !== 1'b1) begin failures++; $display("FAIL midrst_pre_ack got=%0h exp=1", dbg_ack); end
    #2; reset = 0; #1;
    checks++; if (dbg_ack !== 1'b0) begin failures++; $display("FAIL midrst_async_ack got=%0h exp=0", dbg_ack); end
    checks++; if (dut.state !== 1'b0) begin failures++; $display("FAIL midrst_state got=%0h exp=0", dut.state); end
    dbg_req = 0; step(); reset = 1; step();
    dbg_req = 1; dbg_adr = 7; #2;
    checks++; if (mem_adr !== 3'd7) begin failures++; $display("FAIL midrst_regrant_adr got=%0h exp=7", mem_adr); end
    step();
    checks++; if (dbg_ack !== 1'b1) begin failures++; $display("FAIL midrst_regrant_ack got=%0h exp=1", dbg_ack); end
    checks++; if (dbg_rd !== 8'hA5) begin failures++; $display("FAIL midrst_regrant_rd got=%0h exp=a5", dbg_rd); end
    dbg_req = 0; step();
    checks++; if (dbg_ack !== 1'b0) begin failures++; $display("FAIL midrst_ack_fall got=%0h exp=0", dbg_ack); end
  endtask

  initial begin
    #1;
    test_reset();
    test_core_only();
    test_debug_read();
    test_starvation();
    test_held_request();
    test_reset_mid_handshake();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
